// File: rtl/pipeline_hazard_pkg.sv
// Shared pipeline definitions: hazard FSM states, stall-counter width and
// the stage-register control encodings driven by the hazard controller.
package pipeline_hazard_pkg;

  localparam int STALL_CNT_W = 16;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } hazard_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic memwb_flush;
  } stage_ctrl_t;

  // Bit order follows the struct: five enables (PC..MEM/WB), then three flushes.
  localparam stage_ctrl_t CTRL_RUN       = 8'b11111_000;
  localparam stage_ctrl_t CTRL_RESET     = 8'b00000_111;
  localparam stage_ctrl_t CTRL_MEM_STALL = 8'b00001_001;
  localparam stage_ctrl_t CTRL_LOAD_USE  = 8'b00111_010;
  localparam stage_ctrl_t CTRL_BRANCH    = 8'b11111_110;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + STALL_CNT_W'(1);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: the load in ID/EX writes a register the
// instruction in ID is about to read. x0 never creates a dependency.
module load_use_detect (
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic [4:0] i_idex_rd,
  input  logic       i_idex_mem_read,
  output logic       o_load_use
);

  logic w_rd_nonzero;
  logic w_rs_match;

  assign w_rd_nonzero = (i_idex_rd != 5'd0);
  assign w_rs_match   = (i_idex_rd == i_id_rs1) || (i_idex_rd == i_id_rs2);
  assign o_load_use   = i_idex_mem_read && w_rd_nonzero && w_rs_match;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: freezes the pipe on slow memory, inserts a
// bubble on load-use and squashes the wrong path on a taken branch.
module pipeline_hazard_ctrl
  import pipeline_hazard_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic [4:0]             idex_rd,
  input  logic                   idex_mem_read,
  input  logic                   exmem_mem_valid,
  input  logic                   mem_ready,
  input  logic                   branch_taken,
  output logic                   pc_en,
  output logic                   ifid_en,
  output logic                   idex_en,
  output logic                   exmem_en,
  output logic                   memwb_en,
  output logic                   ifid_flush,
  output logic                   idex_flush,
  output logic                   memwb_flush,
  output logic                   mem_wait,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  hazard_state_t          r_state;
  logic [STALL_CNT_W-1:0] r_stall_cycles;
  logic                   w_load_use;
  logic                   w_mem_stall;
  logic                   w_lu_stall;
  stage_ctrl_t            w_ctrl;

  load_use_detect u_load_use_detect (
    .i_id_rs1        (id_rs1),
    .i_id_rs2        (id_rs2),
    .i_idex_rd       (idex_rd),
    .i_idex_mem_read (idex_mem_read),
    .o_load_use      (w_load_use)
  );

  assign w_mem_stall = exmem_mem_valid && !mem_ready;
  // A branch squashes the dependent instruction, so load-use only stalls without one.
  assign w_lu_stall  = w_load_use && !w_mem_stall && !branch_taken;

  // NOTE: every path starts from a default so no latch is inferred.
  always_comb begin
    w_ctrl = CTRL_RUN;
    if (rst)                w_ctrl = CTRL_RESET;
    else if (w_mem_stall)   w_ctrl = CTRL_MEM_STALL;
    else if (branch_taken)  w_ctrl = CTRL_BRANCH;
    else if (w_load_use)    w_ctrl = CTRL_LOAD_USE;
  end

  // NOTE: state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_RUN;
      r_stall_cycles <= '0;
    end else begin
      case (r_state)
        ST_RUN:      if (w_mem_stall) r_state <= ST_MEM_WAIT;
        ST_MEM_WAIT: if (mem_ready)   r_state <= ST_RUN;
        default:                      r_state <= ST_RUN;
      endcase
      if (w_mem_stall || w_lu_stall)
        r_stall_cycles <= sat_inc(r_stall_cycles);
    end
  end

  assign pc_en        = w_ctrl.pc_en;
  assign ifid_en      = w_ctrl.ifid_en;
  assign idex_en      = w_ctrl.idex_en;
  assign exmem_en     = w_ctrl.exmem_en;
  assign memwb_en     = w_ctrl.memwb_en;
  assign ifid_flush   = w_ctrl.ifid_flush;
  assign idex_flush   = w_ctrl.idex_flush;
  assign memwb_flush  = w_ctrl.memwb_flush;
  assign mem_wait     = (r_state == ST_MEM_WAIT);
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: the driver queues hand-computed
// expectations per cycle, the monitor pops and compares at the falling edge.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, idex_rd;
  logic        idex_mem_read, exmem_mem_valid, mem_ready, branch_taken;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, memwb_flush;
  logic        mem_wait;
  logic [15:0] stall_cycles;

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_flush}
  localparam logic [7:0] E_RST = 8'b00000_111;
  localparam logic [7:0] E_RUN = 8'b11111_000;
  localparam logic [7:0] E_MEM = 8'b00001_001;
  localparam logic [7:0] E_LU  = 8'b00111_010;
  localparam logic [7:0] E_BR  = 8'b11111_110;

  typedef struct {
    string       name;
    logic [7:0]  ctrl;
    logic        wt;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  pipeline_hazard_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .idex_rd         (idex_rd),
    .idex_mem_read   (idex_mem_read),
    .exmem_mem_valid (exmem_mem_valid),
    .mem_ready       (mem_ready),
    .branch_taken    (branch_taken),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .idex_en         (idex_en),
    .exmem_en        (exmem_en),
    .memwb_en        (memwb_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .memwb_flush     (memwb_flush),
    .mem_wait        (mem_wait),
    .stall_cycles    (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge; optionally queue the expectation.
  task automatic step(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic mrd, input logic mv,
                      input logic mr, input logic br, input logic [7:0] e_ctrl,
                      input logic e_wait, input logic [15:0] e_cnt,
                      input string name, input bit do_check);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_rs1 = rs1; id_rs2 = rs2; idex_rd = rd;
    idex_mem_read = mrd; exmem_mem_valid = mv; mem_ready = mr; branch_taken = br;
    if (do_check) begin
      e.name = name; e.ctrl = e_ctrl; e.wt = e_wait; e.cnt = e_cnt;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: compares whatever expectation is pending for the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".ctrl"}, 16'({pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                                      ifid_flush, idex_flush, memwb_flush}), 16'(e.ctrl));
        check({e.name, ".mem_wait"}, 16'(mem_wait), 16'(e.wt));
        check({e.name, ".stall_cycles"}, stall_cycles, e.cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; id_rs1 = '0; id_rs2 = '0; idex_rd = '0;
    idex_mem_read = 1'b0; exmem_mem_valid = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
    //   rst rs1 rs2 rd  mrd mv  mr  br   ctrl   wait cnt
    step(1, 0, 0, 0, 0, 0, 0, 0, E_RST, 0, 0, "rst_init", 0);
    step(1, 3, 3, 3, 1, 1, 0, 1, E_RST, 0, 0, "rst_forced", 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0, 0, "idle0", 1);
    step(0, 3, 5, 5, 1, 0, 0, 0, E_LU,  0, 0, "load_use_rs2", 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0, 1, "after_lu", 1);
    step(0, 0, 0, 0, 1, 0, 0, 0, E_RUN, 0, 1, "rd_zero", 1);
    step(0, 7, 2, 7, 1, 0, 0, 0, E_LU,  0, 1, "load_use_rs1", 1);
    step(0, 7, 2, 7, 0, 0, 0, 0, E_RUN, 0, 2, "not_load", 1);
    step(0, 0, 0, 0, 0, 1, 0, 0, E_MEM, 0, 2, "mem_stall1", 1);
    step(0, 0, 0, 0, 0, 1, 0, 0, E_MEM, 1, 3, "mem_stall2", 1);
    step(0, 0, 0, 0, 0, 1, 0, 0, E_MEM, 1, 4, "mem_stall3", 1);
    step(0, 0, 0, 0, 0, 1, 1, 0, E_RUN, 1, 5, "mem_release", 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0, 5, "after_mem", 1);
    step(0, 9, 1, 9, 1, 0, 0, 1, E_BR,  0, 5, "branch_over_lu", 1);
    step(0, 0, 0, 0, 0, 1, 0, 1, E_MEM, 0, 5, "branch_in_stall1", 1);
    step(0, 4, 0, 4, 1, 1, 0, 1, E_MEM, 1, 6, "branch_in_stall2", 1);
    step(0, 0, 0, 0, 0, 1, 1, 1, E_BR,  1, 7, "branch_on_ready", 1);
    step(0, 0, 0, 0, 0, 1, 0, 0, E_MEM, 0, 7, "enter_wait", 1);
    step(1, 0, 0, 0, 0, 1, 0, 0, E_RST, 1, 8, "rst_in_wait", 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0, 0, "post_rst", 1);
    step(0, 0, 0, 0, 0, 1, 1, 0, E_RUN, 0, 0, "access_ready_now", 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0, 0, "no_wait_taken", 1);

    // Long memory stall drives the counter into saturation.
    for (int i = 0; i < 65540; i++) begin
      step(0, 0, 0, 0, 0, 1, 0, 0, E_MEM, (i > 0), (i > 65535) ? 16'hFFFF : 16'(i),
           $sformatf("sat_%0d", i), (i < 2) || (i >= 65533));
    end
    step(0, 0, 0, 0, 0, 1, 1, 0, E_RUN, 1, 16'hFFFF, "sat_release", 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0, 16'hFFFF, "sat_idle", 1);
    step(0, 6, 6, 6, 1, 0, 0, 0, E_LU,  0, 16'hFFFF, "sat_lu", 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0, 16'hFFFF, "sat_hold", 1);

    @(posedge clk);
    @(posedge clk);
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-004 SHALL have ports: idex_rd  in  5; idex_mem_read  in  1  the ID/EX instruction is a load.
REQ-005 SHALL have ports: exmem_mem_valid  in  1  EX/MEM holds a memory access; mem_ready  in  1  memory completes the access this cycle.
REQ-006 SHALL have port: branch_taken  in  1  EX resolved a taken branch/jump.
REQ-007 SHALL have ports: pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage-register enables.
REQ-008 SHALL have ports: ifid_flush, idex_flush, memwb_flush  out  1 each  load a bubble (all-zero controls) into that register.
REQ-009 SHALL have ports: mem_wait  out  1  FSM is in MEM_WAIT; stall_cycles  out  16  saturating count of stalled cycles.

Function
REQ-010 SHALL implement a two-state FSM: RUN and MEM_WAIT.
REQ-011 The FSM SHALL move RUN->MEM_WAIT when exmem_mem_valid=1 and mem_ready=0, and stay in RUN when mem_ready=1 in the same cycle.
REQ-012 The FSM SHALL move MEM_WAIT->RUN on the first edge where mem_ready=1, and stay in MEM_WAIT otherwise.
REQ-013 mem_stall SHALL be 1 when exmem_mem_valid=1 and mem_ready=0, in either state.
REQ-014 While mem_stall=1: pc_en, ifid_en, idex_en and exmem_en SHALL be 0; memwb_en=1; memwb_flush=1.
REQ-015 All other flushes SHALL be 0 while mem_stall=1, so a concurrent branch_taken or load-use hazard is held and not acted on.
REQ-016 Load-use SHALL be detected when idex_mem_read=1, idex_rd!=0, and idex_rd equals id_rs1 or id_rs2.
REQ-017 On load-use without mem_stall or branch_taken: pc_en=0, ifid_en=0, idex_flush=1, and the remaining enables=1.
REQ-018 On branch_taken without mem_stall: ifid_flush=1 and idex_flush=1, all enables=1; branch_taken SHALL take priority over load-use.
REQ-019 With no condition active, all enables SHALL be 1 and all flushes 0.
REQ-020 Outputs other than mem_wait and stall_cycles SHALL be combinational from current inputs and rst, with zero added latency.
REQ-021 stall_cycles SHALL increment on every edge where mem_stall or load-use stall (REQ-017) is in effect.
REQ-022 stall_cycles SHALL saturate at 16'hFFFF and never wrap.
REQ-023 A flush with its stage enable=0 SHALL NOT occur, except during reset (REQ-025).

Reset
REQ-024 On a clk edge with rst=1, the FSM SHALL go to RUN and stall_cycles to 0; mem_wait SHALL read 0 after that edge.
REQ-025 While rst=1, all enables SHALL be 0 and all flushes 1, regardless of other inputs.
REQ-026 A reset asserted in MEM_WAIT SHALL abandon the outstanding access; after reset the block SHALL be in RUN with no memory of it.

Structure
REQ-027 FSM state encoding and the stall-counter width SHALL live in the shared pipeline package, alongside the stage-register control encodings.
REQ-028 The hazard compare (REQ-016) SHALL be a sub-module named load_use_detect; the FSM and counter SHALL stay in the top.

Verification
REQ-029 Scenario: idex_mem_read=1, idex_rd=5, id_rs2=5 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1; stall_cycles 0->1.
REQ-030 Scenario: idex_rd=0, load, id_rs1=0 -> no stall, all enables=1.
REQ-031 Scenario: exmem_mem_valid=1, mem_ready=0 for 3 cycles, then 1 -> mem_wait=1 for 3 cycles; pipeline enables=0 for 3 cycles; release on the ready cycle; stall_cycles=3.
REQ-032 Scenario: branch_taken=1 coincident with a load-use hazard -> ifid_flush=1, idex_flush=1, pc_en=1.
REQ-033 Scenario: branch_taken=1 during mem_stall -> no flushes until mem_ready=1.
REQ-034 Scenario: rst=1 in MEM_WAIT, then counter preloaded near 16'hFFFF and stalls forced -> FSM returns to RUN with stall_cycles=0; the counter holds at 16'hFFFF.
